alu_pipe: RTL

Parametrised sequential ALU: next generation of the 4-bit combinational ALU model. Operands and opcode enter through a valid/ready handshake. Single-cycle ops return a registered result with status flags. MUL runs as an iterative shift-add sequence. Sits between the operand/opcode source (decoder or testbench driver) and a result consumer that may apply backpressure.

---
 rtl/alu_pipe.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// Sequential ALU with a valid/ready operand port and a registered result port.
// Single-cycle ops return their result the next cycle; MUL iterates one shift-add step per cycle.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf
);

  // state | meaning
  // IDLE  | no result held, ready for a new op
  // BUSY  | MUL shift-add steps in progress
  // HOLD  | result and flags presented, waiting for out_ready

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc_step;
  logic [WIDTH-1:0]     mplier;
  logic [CW-1:0]        cnt;
  logic                 accept;

  logic [WIDTH-1:0]     res_c;
  logic                 carry_c;
  logic                 ovf_c;
  logic [WIDTH:0]       sum_w;
  logic [WIDTH:0]       diff_w;
  logic [WIDTH:0]       shl_w;
  logic [WIDTH:0]       shr_w;

  assign in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
  assign accept   = in_valid && in_ready;

  // Shifts run one bit wider than the operand so the last bit shifted out
  // lands in the extra bit; oversized amounts shift everything away.
  always_comb begin
    sum_w   = {1'b0, operand_1} + {1'b0, operand_2};
    diff_w  = {1'b0, operand_1} - {1'b0, operand_2};
    shl_w   = {1'b0, operand_1} << operand_2;
    shr_w   = {operand_1, 1'b0} >> operand_2;
    res_c   = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    case (opcode)
      OP_ADD: begin
        res_c   = sum_w[WIDTH-1:0];
        carry_c = sum_w[WIDTH];
        ovf_c   = (operand_1[WIDTH-1] == operand_2[WIDTH-1]) &&
                  (sum_w[WIDTH-1] != operand_1[WIDTH-1]);
      end
      OP_SUB: begin
        res_c   = diff_w[WIDTH-1:0];
        carry_c = diff_w[WIDTH];
        ovf_c   = (operand_1[WIDTH-1] != operand_2[WIDTH-1]) &&
                  (diff_w[WIDTH-1] != operand_1[WIDTH-1]);
      end
      OP_AND: res_c = operand_1 & operand_2;
      OP_OR:  res_c = operand_1 | operand_2;
      OP_XOR: res_c = operand_1 ^ operand_2;
      OP_SHL: begin
        res_c   = shl_w[WIDTH-1:0];
        carry_c = shl_w[WIDTH];
      end
      OP_SHR: begin
        res_c   = shr_w[WIDTH:1];
        carry_c = shr_w[0];
      end
      default: begin
        res_c   = '0;
        carry_c = 1'b0;
      end
    endcase
  end

  assign acc_step = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      alu_out    <= '0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      flag_ovf   <= 1'b0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      cnt        <= '0;
    end else if (accept) begin
      if (opcode == OP_MUL) begin
        state     <= BUSY;
        out_valid <= 1'b0;
        acc       <= '0;
        mcand     <= {{WIDTH{1'b0}}, operand_1};
        mplier    <= operand_2;
        cnt       <= CW'(WIDTH - 1);
      end else begin
        state      <= HOLD;
        out_valid  <= 1'b1;
        alu_out    <= res_c;
        flag_zero  <= (res_c == '0);
        flag_carry <= carry_c;
        flag_ovf   <= ovf_c;
      end
    end else if ((state == HOLD) && out_ready) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else if (state == BUSY) begin
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
      // terminal count: this edge applies the last partial product
      if (cnt == '0) begin
        state      <= HOLD;
        out_valid  <= 1'b1;
        alu_out    <= acc_step[WIDTH-1:0];
        flag_zero  <= (acc_step[WIDTH-1:0] == '0);
        flag_carry <= |acc_step[2*WIDTH-1:WIDTH];
        flag_ovf   <= 1'b0;
      end
    end
  end

endmodule
